// File: rtl/bcd_scan_counter_pkg.sv
// Shared BCD definitions for every block that produces decimal digits.
// Nibbles above 9 are sanitized to 0 so that downstream 7-seg decoders only ever see 0-9.
package bcd_scan_counter_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  function automatic bcd_digit_t bcd_sanitize(input logic [3:0] nibble);
    return (nibble > BCD_MAX) ? 4'd0 : nibble;
  endfunction

endpackage

// File: rtl/bcd_scan_counter_digit_cell.sv
// One BCD digit of the counter chain: load, increment or decrement,
// with a ripple carry/borrow passed to the next digit.
module bcd_digit_cell
  import bcd_scan_counter_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       up_dn,
  input  logic       load,
  input  logic [3:0] load_nib,
  input  logic       cin,
  output logic [3:0] digit,
  output logic       cout
);

  bcd_digit_t digit_q, digit_d;

  // cin already carries "all lower digits are at their wrap value and a step is requested".
  assign cout  = cin & (up_dn ? (digit_q == BCD_MAX) : (digit_q == 4'd0));
  assign digit = digit_q;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = bcd_sanitize(load_nib);
    end else if (cin) begin
      if (up_dn) digit_d = (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
      else       digit_d = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) digit_q <= 4'd0;
    else          digit_q <= digit_d;
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a time-multiplexed one-hot digit scan
// feeding a single shared 7-seg decoder nibble.
module bcd_scan_counter
  import bcd_scan_counter_pkg::*;
#(
  parameter int unsigned NDIG     = 4,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              count_en,
  input  logic              up_dn,
  input  logic              load,
  input  logic [4*NDIG-1:0] load_val,
  output logic [4*NDIG-1:0] value,
  output logic [3:0]        digit_bcd,
  output logic [NDIG-1:0]   digit_sel,
  output logic              carry,
  output logic              load_err
);

  localparam int unsigned IW = $clog2(NDIG);
  localparam int unsigned PW = $clog2(SCAN_DIV);

  logic [NDIG:0]   cy;
  logic [PW-1:0]   presc_q, presc_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NDIG-1:0] sel_q, sel_d;
  logic [3:0]      bcd_q, bcd_d;
  logic            carry_q, load_err_q, bad_nib;

  // Load takes priority: a count request in the same cycle never enters the chain.
  assign cy[0] = count_en & ~load;

  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk      (clk),
      .reset_n  (reset_n),
      .up_dn    (up_dn),
      .load     (load),
      .load_nib (load_val[4*g +: 4]),
      .cin      (cy[g]),
      .digit    (value[4*g +: 4]),
      .cout     (cy[g+1])
    );
  end

  always_comb begin
    bad_nib = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (load_val[4*i +: 4] > BCD_MAX) bad_nib = 1'b1;
    end
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  // Select and nibble are both derived from the next index so they switch on the same edge.
  always_comb begin
    sel_d = '0;
    bcd_d = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_d == IW'(i)) begin
        sel_d[i] = 1'b1;
        bcd_d    = value[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q    <= '0;
      idx_q      <= '0;
      sel_q      <= NDIG'(1);
      bcd_q      <= 4'd0;
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      bcd_q      <= bcd_d;
      carry_q    <= cy[NDIG];
      load_err_q <= load & bad_nib;
    end
  end

  assign digit_sel = sel_q;
  assign digit_bcd = bcd_q;
  assign carry     = carry_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Self-checking bench: directed scenarios then random traffic against a decimal-integer model.
module tb_bcd_scan_counter;

  localparam int NDIG = 4;
  localparam int SDIV = 4;
  localparam int MODV = 10000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        count_en = 1'b0;
  logic        up_dn = 1'b1;
  logic        load = 1'b0;
  logic [15:0] load_val = '0;
  logic [15:0] value;
  logic [3:0]  digit_bcd;
  logic [3:0]  digit_sel;
  logic        carry;
  logic        load_err;

  int checks = 0;
  int errors = 0;

  // Model state: plain decimal count, cycles since reset release, last scanned nibble.
  int   m_val = 0;
  int   m_cyc = 0;
  int   m_bcd = 0;
  logic m_carry = 0;
  logic m_err = 0;

  bcd_scan_counter #(.NDIG(NDIG), .SCAN_DIV(SDIV)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .count_en  (count_en),
    .up_dn     (up_dn),
    .load      (load),
    .load_val  (load_val),
    .value     (value),
    .digit_bcd (digit_bcd),
    .digit_sel (digit_sel),
    .carry     (carry),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
    end
    return r;
  endfunction

  function automatic int digit_of(input int v, input int pos);
    return (v / (10 ** pos)) % 10;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int idx;
    idx = (m_cyc / SDIV) % NDIG;
    chk({tag, ":value"}, 32'(value), 32'(to_bcd(m_val)));
    chk({tag, ":sel"}, 32'(digit_sel), 32'(1 << idx));
    chk({tag, ":bcd"}, 32'(digit_bcd), 32'(m_bcd));
    chk({tag, ":carry"}, 32'(carry), 32'(m_carry));
    chk({tag, ":lerr"}, 32'(load_err), 32'(m_err));
    chk({tag, ":onehot"}, 32'($onehot(digit_sel)), 32'd1);
    for (int i = 0; i < NDIG; i++) begin
      chk({tag, ":nib"}, 32'(value[4*i +: 4] <= 4'd9), 32'd1);
    end
    chk({tag, ":bcdrange"}, 32'(digit_bcd <= 4'd9), 32'd1);
  endtask

  // One clock: model applies the inputs currently driven, then outputs are compared at negedge.
  task automatic step(input string tag);
    int new_idx, lv, nib;
    logic bad;
    @(posedge clk);
    m_cyc++;
    new_idx = (m_cyc / SDIV) % NDIG;
    m_bcd   = digit_of(m_val, new_idx);
    m_carry = 1'b0;
    m_err   = 1'b0;
    if (load) begin
      lv = 0;
      bad = 1'b0;
      for (int i = NDIG - 1; i >= 0; i--) begin
        nib = int'(load_val[4*i +: 4]);
        if (nib > 9) begin
          bad = 1'b1;
          nib = 0;
        end
        lv = lv * 10 + nib;
      end
      m_val = lv;
      m_err = bad;
    end else if (count_en) begin
      if (up_dn) begin
        m_carry = (m_val == MODV - 1);
        m_val   = (m_val + 1) % MODV;
      end else begin
        m_carry = (m_val == 0);
        m_val   = (m_val + MODV - 1) % MODV;
      end
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic drive(input logic ce, input logic ud, input logic ld, input logic [15:0] lv);
    count_en = ce;
    up_dn    = ud;
    load     = ld;
    load_val = lv;
  endtask

  initial begin
    // Reset state
    #12;
    chk("reset:value", 32'(value), 32'h0);
    chk("reset:sel", 32'(digit_sel), 32'h1);
    chk("reset:bcd", 32'(digit_bcd), 32'h0);
    chk("reset:carry", 32'(carry), 32'h0);
    chk("reset:lerr", 32'(load_err), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Ten up pulses from zero
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0, '0);
      step("up10");
      drive(1'b0, 1'b1, 1'b0, '0);
      step("up10idle");
    end
    chk("up10:const", 32'(value), 32'h0010);

    // 9999 up wraps to 0 with single-cycle carry
    drive(1'b0, 1'b1, 1'b1, 16'h9999);
    step("ld9999");
    drive(1'b1, 1'b1, 1'b0, '0);
    step("wrapup");
    chk("wrapup:const", 32'(carry), 32'h1);
    drive(1'b0, 1'b1, 1'b0, '0);
    step("wrapup_after");

    // 0 down wraps to 9999; 1000 down gives 0999
    drive(1'b1, 1'b0, 1'b0, '0);
    step("wrapdn");
    chk("wrapdn:const", 32'(value), 32'h9999);
    drive(1'b0, 1'b0, 1'b1, 16'h1000);
    step("ld1000");
    drive(1'b1, 1'b0, 1'b0, '0);
    step("dn1000");
    chk("dn1000:const", 32'(value), 32'h0999);
    drive(1'b0, 1'b0, 1'b0, '0);
    step("dn_idle");

    // Invalid nibble load, then load beating count
    drive(1'b0, 1'b1, 1'b1, 16'h12A4);
    step("ld12A4");
    chk("ld12A4:const", 32'(value), 32'h1204);
    drive(1'b0, 1'b1, 1'b0, '0);
    step("ld12A4_after");
    drive(1'b1, 1'b1, 1'b1, 16'h0042);
    step("ldwins");
    chk("ldwins:const", 32'(value), 32'h0042);

    // Free-running scan over 0x4321
    drive(1'b0, 1'b1, 1'b1, 16'h4321);
    step("ld4321");
    drive(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 24; i++) step("scan");

    // Reset mid-scan at idx 2 with value 0567
    drive(1'b0, 1'b1, 1'b1, 16'h0567);
    step("ld0567");
    drive(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 40 && ((m_cyc / SDIV) % NDIG) != 2; i++) step("seek2");
    chk("seek2:sel", 32'(digit_sel), 32'h4);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst:value", 32'(value), 32'h0);
    chk("midrst:sel", 32'(digit_sel), 32'h1);
    chk("midrst:bcd", 32'(digit_bcd), 32'h0);
    m_val = 0; m_cyc = 0; m_bcd = 0; m_carry = 0; m_err = 0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step("postrst");
    chk("postrst:noadv", 32'(digit_sel), 32'h1);
    step("postrst_adv");
    chk("postrst:adv", 32'(digit_sel), 32'h2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [15:0] lv;
      lv = 16'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        for (int d = 0; d < NDIG; d++) lv[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) == 0), lv);
      step("rand");
    end
    // Force a few wraps under random-style drive
    drive(1'b0, 1'b1, 1'b1, 16'h9998);
    step("rload");
    drive(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) step("rwrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
